// File: rtl/tone_sequencer.sv
// Note-table scheduler driving one phase-accumulator oscillator from a programmable table.
// Optional inter-note silence is built when TONE_SEQ_GAP_EN is defined.
module tone_sequencer #(
    parameter int BIT_WIDTH   = 16,
    parameter int DUR_WIDTH   = 16,
    parameter int DEPTH       = 16,
    parameter int GAP_SAMPLES = 480
) (
    input  logic                     clk_audio,
    input  logic                     rst_n,
    input  logic                     sample_tick,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [BIT_WIDTH-1:0]     wr_inc,
    input  logic [DUR_WIDTH-1:0]     wr_dur,
    output logic [BIT_WIDTH-1:0]     osc_inc,
    output logic                     osc_en,
    output logic                     osc_clear,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     done
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef TONE_SEQ_GAP_EN
    localparam int GAP_W = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
`endif

    state_t                 state, state_d;
    logic [IDX_W-1:0]       idx_d;
    logic [DUR_WIDTH-1:0]   cnt, cnt_d;
    logic [BIT_WIDTH-1:0]   inc_d;
    logic                   en_d, clear_d, busy_d, done_d;
    logic [BIT_WIDTH-1:0]   rd_inc;
    logic [DUR_WIDTH-1:0]   rd_dur;
    logic [BIT_WIDTH-1:0]   inc_mem [DEPTH];
    logic [DUR_WIDTH-1:0]   dur_mem [DEPTH];
`ifdef TONE_SEQ_GAP_EN
    logic [GAP_W-1:0]       gap_cnt, gap_cnt_d;
`endif

    // Read address follows the next index so FETCH always sees the entry it is about to play.
    always_ff @(posedge clk_audio) begin
        if (wr_en && !busy) begin
            inc_mem[wr_addr] <= wr_inc;
            dur_mem[wr_addr] <= wr_dur;
        end
        rd_inc <= inc_mem[idx_d];
        rd_dur <= dur_mem[idx_d];
    end

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            note_idx  <= '0;
            cnt       <= '0;
            osc_inc   <= '0;
            osc_en    <= 1'b0;
            osc_clear <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            state     <= state_d;
            note_idx  <= idx_d;
            cnt       <= cnt_d;
            osc_inc   <= inc_d;
            osc_en    <= en_d;
            osc_clear <= clear_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef TONE_SEQ_GAP_EN
            gap_cnt   <= gap_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = note_idx;
        cnt_d   = cnt;
        inc_d   = osc_inc;
        en_d    = osc_en;
        clear_d = 1'b0;
        done_d  = 1'b0;
`ifdef TONE_SEQ_GAP_EN
        gap_cnt_d = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                if (rd_dur == '0) begin
                    // A marker at entry 0 cannot loop usefully, so it always ends the sequence.
                    if (loop && note_idx != '0) begin
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        inc_d   = '0;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = PLAY;
                    cnt_d   = rd_dur;
                    inc_d   = rd_inc;
                    clear_d = 1'b1;
                    en_d    = 1'b1;
                end
            end
            PLAY: begin
                if (sample_tick) begin
                    cnt_d = cnt - DUR_WIDTH'(1);
                    if (cnt == DUR_WIDTH'(1)) begin
                        en_d  = 1'b0;
                        idx_d = note_idx + IDX_W'(1);
`ifdef TONE_SEQ_GAP_EN
                        if (GAP_SAMPLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_W'(GAP_SAMPLES);
                        end else begin
                            state_d = FETCH;
                        end
`else
                        state_d = FETCH;
`endif
                    end
                end
            end
`ifdef TONE_SEQ_GAP_EN
            GAP: begin
                if (sample_tick) begin
                    gap_cnt_d = gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        state_d = FETCH;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (stop && state != IDLE) begin
            state_d = IDLE;
            inc_d   = '0;
            en_d    = 1'b0;
            clear_d = 1'b0;
            done_d  = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: play/end, loop, wrap, write protection, stop/start, async reset.
// Inter-note gap checks follow TONE_SEQ_GAP_EN when it is defined for the build.
module tb_tone_sequencer;

    localparam int BW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int IW    = $clog2(DEPTH);

    logic          clk_audio = 1'b0;
    logic          rst_n;
    logic          sample_tick, start, stop, loop, wr_en;
    logic [IW-1:0] wr_addr;
    logic [BW-1:0] wr_inc;
    logic [DW-1:0] wr_dur;
    logic [BW-1:0] osc_inc;
    logic          osc_en, osc_clear, busy, done;
    logic [IW-1:0] note_idx;

    int assertions = 0;
    int failures   = 0;
    int clear_count = 0;
    int done_count  = 0;
    int clear_base, done_base;

    tone_sequencer #(
        .BIT_WIDTH(BW), .DUR_WIDTH(DW), .DEPTH(DEPTH), .GAP_SAMPLES(GAP)
    ) dut (
        .clk_audio(clk_audio), .rst_n(rst_n), .sample_tick(sample_tick),
        .start(start), .stop(stop), .loop(loop), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_inc(wr_inc), .wr_dur(wr_dur),
        .osc_inc(osc_inc), .osc_en(osc_en), .osc_clear(osc_clear),
        .busy(busy), .note_idx(note_idx), .done(done)
    );

    always #5 clk_audio = ~clk_audio;

    // Pulse counters see each registered one-cycle pulse at exactly one rising edge.
    always @(posedge clk_audio) begin
        if (osc_clear === 1'b1) clear_count++;
        if (done === 1'b1) done_count++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic tick_edge();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
    endtask

    task automatic write_entry(input logic [IW-1:0] a, input logic [BW-1:0] i, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_inc = i; wr_dur = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic note_on(input logic [BW-1:0] exp_inc);
        cycle();
        check_output("note_en", 32'(osc_en), 32'd1);
        check_output("note_clear", 32'(osc_clear), 32'd1);
        check_output("note_inc", 32'(osc_inc), 32'(exp_inc));
        cycle();
        check_output("clear_pulse", 32'(osc_clear), 32'd0);
        cycle();
    endtask

    task automatic start_seq(input logic [BW-1:0] exp_inc);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_output("start_busy", 32'(busy), 32'd1);
        check_output("start_idx", 32'(note_idx), 32'd0);
        check_output("start_en", 32'(osc_en), 32'd0);
        note_on(exp_inc);
    endtask

    task automatic plain_tick();
        tick_edge();
        check_output("play_en", 32'(osc_en), 32'd1);
        check_output("play_busy", 32'(busy), 32'd1);
        repeat (3) cycle();
    endtask

    // Final tick of a note; leaves the sequencer in FETCH for the next entry.
    task automatic advance(input logic [IW-1:0] exp_idx);
        tick_edge();
        check_output("adv_en", 32'(osc_en), 32'd0);
        check_output("adv_idx", 32'(note_idx), 32'(exp_idx));
`ifdef TONE_SEQ_GAP_EN
        for (int g = 0; g < GAP; g++) begin
            repeat (3) cycle();
            check_output("gap_en_pre", 32'(osc_en), 32'd0);
            tick_edge();
            check_output("gap_en", 32'(osc_en), 32'd0);
            check_output("gap_busy", 32'(busy), 32'd1);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0; sample_tick = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_inc = '0; wr_dur = '0;
        repeat (3) cycle();
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_en", 32'(osc_en), 32'd0);
        check_output("rst_inc", 32'(osc_inc), 32'd0);
        check_output("rst_idx", 32'(note_idx), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Two notes then an end marker, no looping.
        write_entry(0, 16'h0147, 16'd3);
        write_entry(1, 16'h028E, 16'd2);
        write_entry(2, 16'h0000, 16'd0);
        clear_base = clear_count; done_base = done_count;
        start_seq(16'h0147);
        plain_tick();
        plain_tick();
        advance(1);
        note_on(16'h028E);
        plain_tick();
        advance(2);
        cycle();
        check_output("end_done", 32'(done), 32'd1);
        check_output("end_busy", 32'(busy), 32'd0);
        check_output("end_inc", 32'(osc_inc), 32'd0);
        check_output("end_en", 32'(osc_en), 32'd0);
        cycle();
        check_output("end_done_off", 32'(done), 32'd0);
        check_output("clear_pulses", 32'(clear_count - clear_base), 32'd2);
        check_output("done_pulses", 32'(done_count - done_base), 32'd1);

        // Same table looping, then aborted with stop.
        loop = 1'b1;
        done_base = done_count;
        start_seq(16'h0147);
        plain_tick();
        plain_tick();
        advance(1);
        note_on(16'h028E);
        plain_tick();
        advance(2);
        cycle();
        check_output("loop_idx", 32'(note_idx), 32'd0);
        check_output("loop_busy", 32'(busy), 32'd1);
        note_on(16'h0147);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_output("stop_busy", 32'(busy), 32'd0);
        check_output("stop_en", 32'(osc_en), 32'd0);
        check_output("stop_inc", 32'(osc_inc), 32'd0);
        cycle();
        check_output("loop_no_done", 32'(done_count - done_base), 32'd0);

        // Full table of one-sample notes wraps past the last entry; writes while busy are dropped.
        loop = 1'b0;
        write_entry(0, 16'h0010, 16'd1);
        write_entry(1, 16'h0020, 16'd1);
        write_entry(2, 16'h0030, 16'd1);
        write_entry(3, 16'h0040, 16'd1);
        start_seq(16'h0010);
        write_entry(0, 16'hBEEF, 16'd0);
        advance(1);
        note_on(16'h0020);
        advance(2);
        note_on(16'h0030);
        advance(3);
        note_on(16'h0040);
        advance(0);
        check_output("wrap_busy", 32'(busy), 32'd1);
        note_on(16'h0010);
        advance(1);
        note_on(16'h0020);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_output("wrap_stop_busy", 32'(busy), 32'd0);
        cycle();
        start_seq(16'h0010);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_output("reread_stop", 32'(busy), 32'd0);

        // start and stop together in IDLE must not start anything.
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check_output("ss_busy", 32'(busy), 32'd0);
        cycle();
        check_output("ss_busy2", 32'(busy), 32'd0);
        check_output("ss_en", 32'(osc_en), 32'd0);

        // Asynchronous reset in the middle of a note.
        start_seq(16'h0010);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("arst_en", 32'(osc_en), 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_inc", 32'(osc_inc), 32'd0);
        check_output("arst_idx", 32'(note_idx), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        check_output("arst_after", 32'(busy), 32'd0);

        // End marker at entry 0 with loop set ends immediately instead of spinning.
        loop = 1'b1;
        write_entry(0, 16'h0000, 16'd0);
        done_base = done_count;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_output("m0_busy", 32'(busy), 32'd1);
        cycle();
        check_output("m0_done", 32'(done), 32'd1);
        check_output("m0_idle", 32'(busy), 32'd0);
        repeat (3) cycle();
        check_output("m0_one_done", 32'(done_count - done_base), 32'd1);
        check_output("m0_still_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
